// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pseudo-random pulse generator: LFSR constants,
// FSM state encoding and the LFSR step function.
package pulse_gen_pkg;

  localparam int LFSR_W = 16;

  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    GAP   = 1'b0,
    PULSE = 1'b1
  } state_e;

  function automatic logic [LFSR_W-1:0] next_lfsr(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that steps only when adv is high.
// Its reset value is one step past SEED, because the first gap is drawn from SEED itself.
module lfsr16
  import pulse_gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              adv,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] r_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q <= next_lfsr(SEED);
    end else if (adv) begin
      // An all-zero register would lock up, so reload the seed instead.
      r_q <= (r_q == '0) ? SEED : next_lfsr(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pulse_generation.sv
// Free-running pulse source: a low gap of LFSR-derived length, then a fixed-width high pulse.
// The output is taken straight from a flop, so it has no combinational path.
module pulse_generation
  import pulse_gen_pkg::*;
#(
  parameter int                PULSE_W        = 1,
  parameter int                MIN_GAP        = 2,
  parameter int                GAP_RANGE_LOG2 = 2,
  parameter logic [LFSR_W-1:0] SEED           = 16'hACE1
) (
  input  logic clk,
  input  logic rstn,
  output logic pulse_o
);

  localparam int GAP_MAX = MIN_GAP + (1 << GAP_RANGE_LOG2) - 1;
  localparam int CNT_MAX = (GAP_MAX > PULSE_W) ? GAP_MAX : PULSE_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [LFSR_W-1:0] GAP_MASK = LFSR_W'((32'd1 << GAP_RANGE_LOG2) - 32'd1);
  localparam logic [CNT_W-1:0]  PW_LD    = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0]  G0_LD    = CNT_W'(MIN_GAP + int'(SEED & GAP_MASK));

  if (PULSE_W < 1) begin : g_chk_pulse_w
    $error("pulse_generation: PULSE_W must be >= 1");
  end
  if (MIN_GAP < 1) begin : g_chk_min_gap
    $error("pulse_generation: MIN_GAP must be >= 1");
  end
  if (SEED == '0) begin : g_chk_seed
    $error("pulse_generation: SEED must be nonzero");
  end
  if (GAP_RANGE_LOG2 < 0 || GAP_RANGE_LOG2 > 15) begin : g_chk_range
    $error("pulse_generation: GAP_RANGE_LOG2 must be in 0..15");
  end

  state_e            r_state;
  state_e            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  w_draw_gap;
  logic              r_pulse;
  logic              w_pulse_next;
  logic              w_cnt_done;
  logic              w_adv;
  logic [LFSR_W-1:0] w_lfsr;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk (clk),
    .rstn(rstn),
    .adv (w_adv),
    .q   (w_lfsr)
  );

  assign w_cnt_done = (r_cnt == CNT_W'(1));
  assign w_draw_gap = CNT_W'(MIN_GAP) + CNT_W'(w_lfsr & GAP_MASK);

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= GAP;
      r_cnt   <= G0_LD;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      r_pulse <= w_pulse_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (w_cnt_done) begin
      w_next_state = (r_state == GAP) ? PULSE : GAP;
    end
  end

  // The counter reloads on the edge that ends a phase, so every phase lasts exactly its load value.
  always_comb begin
    w_cnt_next   = r_cnt - CNT_W'(1);
    w_pulse_next = (w_next_state == PULSE);
    w_adv        = 1'b0;
    if (w_cnt_done) begin
      if (r_state == GAP) begin
        w_cnt_next = PW_LD;
      end else begin
        w_cnt_next = w_draw_gap;
        w_adv      = 1'b1;
      end
    end
  end

  assign pulse_o = r_pulse;

endmodule

// File: tb/tb_pulse_generation.sv
// Bench for pulse_generation: default, strictly periodic and wide-range instances,
// checked cycle by cycle against an expected-bit queue built from an independent LFSR model.
module tb_pulse_generation;

  logic clk;
  logic rstn;
  logic p0;
  logic p1;
  logic p2;
  int   sel;

  int vectors;
  int miscompares;

  logic exp_q[$];

  pulse_generation dut_def (
    .clk    (clk),
    .rstn   (rstn),
    .pulse_o(p0)
  );

  pulse_generation #(
    .PULSE_W       (4),
    .MIN_GAP       (1),
    .GAP_RANGE_LOG2(0)
  ) dut_per (
    .clk    (clk),
    .rstn   (rstn),
    .pulse_o(p1)
  );

  pulse_generation #(
    .PULSE_W       (2),
    .MIN_GAP       (2),
    .GAP_RANGE_LOG2(3)
  ) dut_long (
    .clk    (clk),
    .rstn   (rstn),
    .pulse_o(p2)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic obs_bit();
    case (sel)
      0:       return p0;
      1:       return p1;
      default: return p2;
    endcase
  endfunction

  function automatic logic [15:0] tb_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Waits one rising edge, then pops the expected bit and compares it with the selected DUT.
  task automatic step_check(input string tag, output logic obs);
    logic e;
    @(posedge clk);
    #1;
    obs = obs_bit();
    if (exp_q.size() == 0) begin
      check_bit({tag, "_queue_empty"}, 1'b0, 1'b1);
    end else begin
      e = exp_q.pop_front();
      check_bit(tag, obs, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_bit("rst_low", obs_bit(), 1'b0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Expected output stream, one bit per edge starting at E1.
  task automatic push_model(input int pw, input int min_gap, input int grl,
                            input logic [15:0] seed, input int n);
    logic [15:0] l;
    int          g;
    int          pushed;
    bit          first;
    l      = seed;
    pushed = 0;
    first  = 1'b1;
    while (pushed < n) begin
      g = min_gap + int'(l & 16'((1 << grl) - 1));
      l = (l == 16'h0000) ? seed : tb_next(l);
      if (first) g = g - 1;
      first = 1'b0;
      repeat (g) begin
        exp_q.push_back(1'b0);
        pushed++;
      end
      repeat (pw) begin
        exp_q.push_back(1'b1);
        pushed++;
      end
    end
  endtask

  initial begin
    logic o;
    int   run;
    logic prev;
    bit   seen_high;

    vectors     = 0;
    miscompares = 0;
    sel         = 0;
    rstn        = 1'b0;

    // Default instance: reset behaviour, then rises at E3, E9, E15 (draws ACE1, 59C3, B387).
    #2;
    check_bit("rst_async_low", p0, 1'b0);
    @(posedge clk);
    #1;
    check_bit("rst_held_low", p0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      exp_q.push_back((n == 3) || (n == 9) || (n == 15));
    end
    for (int n = 1; n <= 20; n++) begin
      step_check("default_seq", o);
    end

    // Reset while high: output drops before the next edge, then the sequence restarts.
    do_reset();
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    for (int n = 0; n < 3; n++) step_check("pre_midreset", o);
    #1;
    rstn = 1'b0;
    #1;
    check_bit("midpulse_async_drop", p0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    for (int n = 0; n < 6; n++) step_check("restart_seq", o);

    // Periodic instance: 4 high, 1 low, over 20 periods.
    sel = 1;
    exp_q.delete();
    do_reset();
    push_model(4, 1, 0, 16'hACE1, 100);
    for (int n = 0; n < 100; n++) step_check("periodic_seq", o);
    exp_q.delete();

    // Wide-range instance: long run against the model plus gap/width bounds.
    sel = 2;
    do_reset();
    push_model(2, 2, 3, 16'hACE1, 10000);
    run       = 0;
    prev      = 1'b0;
    seen_high = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      step_check("long_seq", o);
      if (n == 0 || o === prev) begin
        run++;
      end else begin
        if (prev === 1'b1) begin
          check_bit("pulse_width", run == 2, 1'b1);
          seen_high = 1'b1;
        end else if (seen_high) begin
          check_bit("gap_range", (run >= 2) && (run <= 9), 1'b1);
        end
        run = 1;
      end
      prev = o;
    end
    exp_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
